// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Holds the lookahead group size, stage count and config legality check.
package cla_pkg;

  localparam int GRP = 4;

  function automatic int stages(input int w, input int c);
    return w / c;
  endfunction

  function automatic bit cfg_ok(input int w, input int c);
    return (c > 0) && (c % GRP == 0) &&
           (w >= c) && (w % c == 0);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_chunk.sv
// cla_chunk: combinational CHUNK-bit two-level carry-lookahead adder.
// Ports: a_i/b_i/cin_i in; sum_o, cout_o, cmsb_o (carry into MSB) out.
module cla_chunk
  import cla_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  localparam int NG = CHUNK / GRP;

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic [CHUNK:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    logic pr;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    pr = 1'b0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[j*GRP +: GRP];
      for (int i = 0; i < GRP; i++) begin
        gg[j] = g[j*GRP+i] | (p[j*GRP+i] & gg[j]);
      end
    end
    // Group carries as flat sum-of-products over
    // group generate/propagate, not a ripple chain.
    gc[0] = cin_i;
    for (int j = 1; j <= NG; j++) begin
      pr = 1'b1;
      for (int m = j - 1; m >= 0; m--) begin
        gc[j] = gc[j] | (gg[m] & pr);
        pr    = pr & gp[m];
      end
      gc[j] = gc[j] | (pr & cin_i);
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GRP; i++) begin
        pr = 1'b1;
        for (int m = i - 1; m >= 0; m--) begin
          c[j*GRP+i] = c[j*GRP+i] | (g[j*GRP+m] & pr);
          pr         = pr & p[j*GRP+m];
        end
        c[j*GRP+i] = c[j*GRP+i] | (pr & gc[j]);
      end
    end
    c[CHUNK] = gc[NG];
  end

  assign sum_o  = p ^ c[CHUNK-1:0];
  assign cout_o = c[CHUNK];
  assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit add/sub, one CHUNK slice per stage, valid/ready
// on both sides; reports sum, carry-out, signed overflow and a tag.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S = stages(WIDTH, CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("cla_pipe_adder: bad WIDTH/CHUNK");
  end

  // Link k feeds stage k; link S is the output.
  // Operand links hold only not-yet-summed slices,
  // right-aligned; sum links hold finished slices.
  logic [WIDTH-1:0] ar [S+1];
  logic [WIDTH-1:0] br [S+1];
  logic [WIDTH-1:0] sr [S+1];
  logic             cr [S+1];
  logic             mr [S+1];
  logic             vr [S+1];
  logic [TAG_W-1:0] tr [S+1];

  logic adv;

  assign adv      = !vr[S] || out_ready;
  assign in_ready = adv;

  assign ar[0] = in_a;
  assign br[0] = in_sub ? ~in_b : in_b;
  assign sr[0] = '0;
  assign cr[0] = in_sub | in_cin;
  assign mr[0] = 1'b0;
  assign vr[0] = in_valid && adv;
  assign tr[0] = in_tag;

  for (genvar k = 0; k < S; k++) begin : g_st
    localparam int LO = (k + 1) * CHUNK;
    localparam int HI = WIDTH - LO;

    logic [CHUNK-1:0] cs;
    logic             co;
    logic             cm;
    logic [LO-1:0]    s_d;
    logic [LO-1:0]    s_q;
    logic             v_q;
    logic             c_q;
    logic             m_q;
    logic [TAG_W-1:0] t_q;

    cla_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i    (ar[k][CHUNK-1:0]),
      .b_i    (br[k][CHUNK-1:0]),
      .cin_i  (cr[k]),
      .sum_o  (cs),
      .cout_o (co),
      .cmsb_o (cm)
    );

    if (k == 0) begin : g_s0
      assign s_d = cs;
    end else begin : g_sn
      assign s_d = {cs, sr[k][LO-CHUNK-1:0]};
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        m_q <= 1'b0;
        t_q <= '0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vr[k];
        c_q <= co;
        m_q <= cm;
        t_q <= tr[k];
        s_q <= s_d;
      end
    end

    assign vr[k+1] = v_q;
    assign cr[k+1] = c_q;
    assign mr[k+1] = m_q;
    assign tr[k+1] = t_q;
    assign sr[k+1] = WIDTH'(s_q);

    if (HI > 0) begin : g_skew
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= ar[k][HI+CHUNK-1:CHUNK];
          b_q <= br[k][HI+CHUNK-1:CHUNK];
        end
      end

      assign ar[k+1] = WIDTH'(a_q);
      assign br[k+1] = WIDTH'(b_q);
    end else begin : g_noskew
      assign ar[k+1] = '0;
      assign br[k+1] = '0;
    end
  end

  assign out_valid = vr[S];
  assign out_sum   = sr[S];
  assign out_cout  = cr[S];
  assign out_ovf   = mr[S] ^ cr[S];
  assign out_tag   = tr[S];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: 32/16 (two stages) and 16/16 (one).
// Tasks cover reset, add/sub flags, throughput, stall and mid-flight reset.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b, out_sum;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready, out_cout, out_ovf;

  logic        s_in_valid, s_in_ready, s_in_cin, s_in_sub;
  logic [15:0] s_in_a, s_in_b, s_out_sum;
  logic [3:0]  s_in_tag, s_out_tag;
  logic        s_out_valid, s_out_ready, s_out_cout, s_out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  cla_pipe_adder #(.WIDTH(32), .CHUNK(16), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf), .out_tag(out_tag)
  );

  cla_pipe_adder #(.WIDTH(16), .CHUNK(16), .TAG_W(4)) u_one (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin),
    .in_sub(s_in_sub), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_cout(s_out_cout),
    .out_ovf(s_out_ovf), .out_tag(s_out_tag)
  );

  wire [38:0] outs = {out_valid, out_sum, out_cout, out_ovf, out_tag};
  wire [22:0] s_outs = {s_out_valid, s_out_sum, s_out_cout,
                        s_out_ovf, s_out_tag};

  localparam logic [31:0] VA [8] = '{
    32'h0000FFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h12345678,
    32'h00000005, 32'h00000007, 32'h80000000, 32'h00000009};
  localparam logic [31:0] VB [8] = '{
    32'h00000001, 32'h00000001, 32'h00000001, 32'h9ABCDEF0,
    32'h00000007, 32'h00000005, 32'h00000001, 32'h00000009};
  localparam bit VCI [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  localparam bit VSB [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  localparam logic [31:0] VS [8] = '{
    32'h00010000, 32'h80000000, 32'h00000000, 32'hACF13569,
    32'hFFFFFFFE, 32'h00000002, 32'h7FFFFFFF, 32'h00000000};
  localparam bit VC [8] = '{0, 0, 1, 0, 0, 1, 1, 1};
  localparam bit VO [8] = '{0, 1, 0, 0, 0, 0, 1, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
    out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0;
    s_in_cin = 1'b0; s_in_sub = 1'b0; s_in_tag = '0;
    s_out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (outs !== 39'h0) begin
      n_bad++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_cmp++;
    if (s_outs !== 23'h0) begin
      n_bad++;
      $display("FAIL reset_s1_outs: got %h want 0", s_outs);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_add_sub();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a = VA[i]; in_b = VB[i];
      in_cin = VCI[i]; in_sub = VSB[i];
      in_tag = 4'(i + 1);
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL latency_%0d: out_valid %b want 0", i, out_valid);
      end
      tick();
      n_cmp++;
      if (outs !== {1'b1, VS[i], VC[i], VO[i], 4'(i + 1)}) begin
        n_bad++;
        $display("FAIL vec_%0d: got %h want %h", i, outs,
                 {1'b1, VS[i], VC[i], VO[i], 4'(i + 1)});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea [3];
    logic [31:0] es [3];
    ea = '{32'h0000FFFF, 32'h0001FFFF, 32'h0002FFFF};
    es = '{32'h00010000, 32'h00020000, 32'h00030000};
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 3);
      if (c < 3) begin
        in_a = ea[c]; in_b = 32'h1;
        in_cin = 1'b0; in_sub = 1'b0;
        in_tag = 4'(10 + c);
      end
      tick();
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        if (outs !== {1'b1, es[c-1], 1'b0, 1'b0, 4'(9 + c)}) begin
          n_bad++;
          $display("FAIL b2b_%0d: got %h want %h", c, outs,
                   {1'b1, es[c-1], 1'b0, 1'b0, 4'(9 + c)});
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_drain: out_valid %b want 0", out_valid);
        end
      end
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int nxt = 0;
    for (int c = 0; c < 20 && nxt < 4; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid = (idx < 4);
      in_a = 32'(idx + 1); in_b = 32'h0000FFFF;
      in_cin = 1'b0; in_sub = 1'b0;
      in_tag = 4'(idx + 1);
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        n_cmp++;
        if (in_ready !== 1'b0 ||
            outs !== {1'b1, 32'h00010000, 1'b0, 1'b0, 4'd1}) begin
          n_bad++;
          $display("FAIL stall_hold_%0d: rdy %b outs %h want 0 / %h",
                   c, in_ready, outs,
                   {1'b1, 32'h00010000, 1'b0, 1'b0, 4'd1});
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if ({out_sum, out_tag} !==
              {32'h0000FFFF + 32'(nxt + 1), 4'(nxt + 1)} ||
            c != 5 + nxt) begin
          n_bad++;
          $display("FAIL stall_order: cyc %0d sum %h tag %0d want cyc %0d tag %0d",
                   c, out_sum, out_tag, 5 + nxt, nxt + 1);
        end
        nxt++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (nxt != 4) begin
      n_bad++;
      $display("FAIL stall_count: got %0d want 4", nxt);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_cin = 1'b0; in_sub = 1'b0;
    in_a = 32'h1; in_b = 32'h2; in_tag = 4'd5;
    tick();
    in_a = 32'h3; in_b = 32'h4; in_tag = 4'd6;
    tick();
    n_cmp++;
    if (outs !== {1'b1, 32'h3, 1'b0, 1'b0, 4'd5}) begin
      n_bad++;
      $display("FAIL rst_mid_loaded: got %h want %h", outs,
               {1'b1, 32'h3, 1'b0, 1'b0, 4'd5});
    end
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_a = 32'h7; in_b = 32'h8; in_tag = 4'd7;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (outs !== 39'h0) begin
      n_bad++;
      $display("FAIL rst_mid_outs: got %h want 0", outs);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_in_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_mid_ghost_%0d: out_valid %b tag %0d want 0",
                 c, out_valid, out_tag);
      end
    end
  endtask

  task automatic test_single_stage();
    logic [15:0] sa [3];
    logic [15:0] sb [3];
    logic [15:0] ss [3];
    bit sc [3];
    bit ssub [3];
    bit sco [3];
    bit sov [3];
    sa = '{16'hFFFF, 16'h7FFF, 16'h0003};
    sb = '{16'hFFFF, 16'h0001, 16'h0005};
    sc = '{1, 0, 0};
    ssub = '{0, 0, 1};
    ss = '{16'hFFFF, 16'h8000, 16'hFFFE};
    sco = '{1, 0, 0};
    sov = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      s_in_valid = 1'b1;
      s_in_a = sa[i]; s_in_b = sb[i];
      s_in_cin = sc[i]; s_in_sub = ssub[i];
      s_in_tag = 4'(12 + i);
      tick();
      s_in_valid = 1'b0;
      n_cmp++;
      if (s_outs !== {1'b1, ss[i], sco[i], sov[i], 4'(12 + i)}) begin
        n_bad++;
        $display("FAIL s1_vec_%0d: got %h want %h", i, s_outs,
                 {1'b1, ss[i], sco[i], sov[i], 4'(12 + i)});
      end
    end
    tick();
    n_cmp++;
    if (s_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL s1_drain: out_valid %b want 0", s_out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the pipeline datapath, generalising the fixed 16-bit adder to any WIDTH. The operand is split into CHUNK-bit slices; one slice is summed per pipeline stage, and the carry is registered between stages. Valid/ready handshakes on both sides let it sit between pipeline registers and absorb downstream stalls. It also reports carry-out and signed overflow, with an in-band tag carried alongside each operation.

## Interface
- WIDTH, 32: operand/sum width; must be a multiple of CHUNK.
- CHUNK, 16: bits summed per stage; must be a multiple of 4.
- TAG_W, 4: width of the opaque tag carried with each operation.
- Derived: S = WIDTH/CHUNK is the stage count and the latency.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_a, in_b  in  WIDTH  operands.
- in_cin  in  1  carry-in for add; ignored when in_sub=1.
- in_sub  in  1  1: compute a + ~b + 1.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry out of the MSB; for subtract, 1 = no borrow (a >= b unsigned).
- out_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- out_tag  out  TAG_W  tag of this result.

## Operation
- Effective b: in_sub ? ~in_b : in_b. Effective cin: in_sub ? 1 : in_cin.
- Stage k (0..S-1) adds slice k using the registered carry from stage k-1. Stage 0 uses the effective cin.
- Upper operand slices not yet consumed travel in skew registers. Completed lower sum slices travel in deskew registers, so all slices leave together.
- Each stage carries a valid bit. One global advance = !out_valid || out_ready.
  - When advance=1, every stage shifts, and stage 0 loads the input if it is accepted, otherwise a bubble.
  - When advance=0, all state holds.
- in_ready = advance. It is combinational from out_ready and out_valid. This is the only combinational input-to-output path.
- Bubbles propagate with valid=0. Results leave in acceptance order with no loss or duplication.
- Reset (rst_n=0 at an edge) behaves the same mid-operation:
  - all valid bits, data, carry and tag registers clear to 0;
  - in-flight operations are discarded;
  - the reset takes priority over a simultaneous handshake.
- Output values after reset: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_tag=0. in_ready=1 from the first cycle after reset.

## Timing
- An operation accepted at edge t with no stall gives out_valid=1 after edge t+S-1, i.e. it is presented in the cycle following edge t+S-1. Latency is S cycles.
- Throughput is one operation per cycle when out_ready is held at 1.
- While out_valid=1 and out_ready=0, all outputs are held stable and in_ready=0.
- Stall release: out_ready=1 at edge e completes the handshake, and the pipe advances at that same edge.
- Critical path: one CHUNK-bit lookahead adder plus the carry register setup.

## Structure
- Shared package/header cla_pkg holds:
  - the lookahead group size constant (4);
  - a stage-count function (WIDTH/CHUNK);
  - elaboration checks: the divisibility rules above, failing elaboration on violation.
- Sub-module cla_chunk is a purely combinational CHUNK-bit adder.
  - Internals: per-bit g/p, 4-bit group lookahead, a second-level lookahead across groups.
  - Outputs: sum, cout, and carry into the MSB (for the overflow flag).
- The top level contains S cla_chunk instances, the skew/deskew shift registers, the valid chain and the handshake.

## Test plan
- WIDTH=32, CHUNK=16: 0x0000FFFF + 0x00000001, cin=0 -> 0x00010000, cout=0, ovf=0, two cycles after acceptance. This checks the carry crossing the stage boundary.
- Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, ovf=1, cout=0. Add 0xFFFFFFFF + 0x00000001 -> 0x00000000, cout=1, ovf=0.
- Subtract with in_cin=1 (must be ignored):
  - 5 - 7 -> 0xFFFFFFFE, cout=0, ovf=0;
  - 7 - 5 -> 0x00000002, cout=1;
  - 0x80000000 - 1 -> 0x7FFFFFFF, ovf=1.
- Stall: offer 4 back-to-back operations with tags 1..4, then hold out_ready=0 for 3 cycles.
  - in_ready must drop and outputs stay constant during the stall.
  - After release, tags 1..4 must emerge in order, one per cycle, none lost.
- Reset mid-flight: rst_n=0 for one edge with 2 operations in the pipe -> next cycle out_valid=0, all outputs 0, in_ready=1, and neither operation is ever emitted.
- WIDTH=16, CHUNK=16 (S=1): 0xFFFF + 0xFFFF with cin=1 -> 0xFFFF, cout=1, ovf=0, latency 1.
